// File: rtl/sprite_eval.sv
// ============================================================================
// Module   : sprite_eval
// Brief    : Per-scanline sprite evaluator; copies visible OAM entries into
//            secondary OAM and reports count / overflow / sprite-0 presence.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_eval #(
    parameter int NUM_SPR  = 64,
    parameter int MAX_LINE = 8,
    parameter int OAW      = $clog2(NUM_SPR*4),
    parameter int SAW      = $clog2(MAX_LINE*4)
) (
    input  logic                          ppu_clk,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic [7:0]                    line,
    input  logic                          tall,
    output logic [OAW-1:0]                oam_addr,
    input  logic [7:0]                    oam_rdata,
    output logic                          sec_we,
    output logic [SAW-1:0]                sec_addr,
    output logic [7:0]                    sec_wdata,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(MAX_LINE+1)-1:0] count,
    output logic                          overflow,
    output logic                          spr0_hit
);

    localparam int NW       = OAW - 2;
    localparam int CW       = $clog2(MAX_LINE+1);
    localparam int CLR_LAST = MAX_LINE*4 - 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_YA    = 3'd2,
        S_YC    = 3'd3,
        S_C1    = 3'd4,
        S_C2    = 3'd5,
        S_C3    = 3'd6,
        S_FIN   = 3'd7
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [NW-1:0]   r_n;
    logic [SAW-1:0]  r_clr;
    logic [7:0]      r_line;
    logic            r_tall;
    logic [CW-1:0]   r_count;
    logic            r_ovf;
    logic            r_spr0;

    logic [8:0]      w_d;
    logic [7:0]      w_limit;
    logic            w_hit;
    logic            w_last;
    logic            w_full;
    logic            w_inc_n;
    logic            w_inc_cnt;
    logic            w_set_ovf;
    logic            w_set_spr0;

    // Unsigned 9-bit difference: a borrow means Y lies below the line, never a hit
    assign w_d     = {1'b0, r_line} - {1'b0, oam_rdata};
    assign w_limit = r_tall ? 8'd16 : 8'd8;
    assign w_hit   = ~w_d[8] && (w_d[7:0] < w_limit);
    assign w_last  = &r_n;
    assign w_full  = (r_count == CW'(MAX_LINE));

    assign count    = r_count;
    assign overflow = r_ovf;
    assign spr0_hit = r_spr0;

    always_ff @(posedge ppu_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        oam_addr    = '0;
        sec_we      = 1'b0;
        sec_addr    = '0;
        sec_wdata   = '0;
        busy        = 1'b0;
        done        = 1'b0;
        w_inc_n     = 1'b0;
        w_inc_cnt   = 1'b0;
        w_set_ovf   = 1'b0;
        w_set_spr0  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_CLEAR;
            end
            S_CLEAR: begin
                busy      = 1'b1;
                sec_we    = 1'b1;
                sec_addr  = r_clr;
                sec_wdata = 8'hFF;
                if (r_clr == SAW'(CLR_LAST)) w_state_nxt = S_YA;
            end
            S_YA: begin
                busy        = 1'b1;
                oam_addr    = {r_n, 2'b00};
                w_state_nxt = S_YC;
            end
            S_YC: begin
                busy     = 1'b1;
                oam_addr = {r_n, 2'b01};
                if (w_hit) begin
                    if (w_full) begin
                        w_set_ovf   = 1'b1;
                        w_state_nxt = S_FIN;
                    end else begin
                        sec_we      = 1'b1;
                        sec_addr    = SAW'({r_count, 2'b00});
                        sec_wdata   = oam_rdata;
                        w_set_spr0  = (r_n == '0);
                        w_state_nxt = S_C1;
                    end
                end else if (w_last) begin
                    w_state_nxt = S_FIN;
                end else begin
                    w_inc_n     = 1'b1;
                    w_state_nxt = S_YA;
                end
            end
            S_C1: begin
                busy        = 1'b1;
                sec_we      = 1'b1;
                sec_addr    = SAW'({r_count, 2'b01});
                sec_wdata   = oam_rdata;
                oam_addr    = {r_n, 2'b10};
                w_state_nxt = S_C2;
            end
            S_C2: begin
                busy        = 1'b1;
                sec_we      = 1'b1;
                sec_addr    = SAW'({r_count, 2'b10});
                sec_wdata   = oam_rdata;
                oam_addr    = {r_n, 2'b11};
                w_state_nxt = S_C3;
            end
            S_C3: begin
                busy      = 1'b1;
                sec_we    = 1'b1;
                sec_addr  = SAW'({r_count, 2'b11});
                sec_wdata = oam_rdata;
                w_inc_cnt = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_FIN;
                end else begin
                    w_inc_n     = 1'b1;
                    w_state_nxt = S_YA;
                end
            end
            S_FIN: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge ppu_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_n     <= '0;
            r_clr   <= '0;
            r_line  <= '0;
            r_tall  <= 1'b0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_spr0  <= 1'b0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_line  <= line;
                r_tall  <= tall;
                r_n     <= '0;
                r_clr   <= '0;
                r_count <= '0;
                r_ovf   <= 1'b0;
                r_spr0  <= 1'b0;
            end
            if (r_state == S_CLEAR) r_clr   <= r_clr + SAW'(1);
            if (w_inc_n)            r_n     <= r_n + NW'(1);
            if (w_inc_cnt)          r_count <= r_count + CW'(1);
            if (w_set_ovf)          r_ovf   <= 1'b1;
            if (w_set_spr0)         r_spr0  <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sprite_eval.sv
// ============================================================================
// Module   : tb_sprite_eval
// Brief    : Directed + random bench for sprite_eval against a list-based model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sprite_eval;

    logic       ppu_clk;
    logic       reset_n;
    logic       start;
    logic [7:0] line;
    logic       tall;
    logic [7:0] oam_addr;
    logic [7:0] oam_rdata;
    logic       sec_we;
    logic [4:0] sec_addr;
    logic [7:0] sec_wdata;
    logic       busy;
    logic       done;
    logic [3:0] count;
    logic       overflow;
    logic       spr0_hit;

    int ncmp  = 0;
    int nfail = 0;
    int nstray = 0;

    logic [7:0] oam [256];
    logic [4:0] wa [$];
    logic [7:0] wd [$];

    sprite_eval #(.NUM_SPR(64), .MAX_LINE(8)) dut (
        .ppu_clk   (ppu_clk),
        .reset_n   (reset_n),
        .start     (start),
        .line      (line),
        .tall      (tall),
        .oam_addr  (oam_addr),
        .oam_rdata (oam_rdata),
        .sec_we    (sec_we),
        .sec_addr  (sec_addr),
        .sec_wdata (sec_wdata),
        .busy      (busy),
        .done      (done),
        .count     (count),
        .overflow  (overflow),
        .spr0_hit  (spr0_hit)
    );

    initial ppu_clk = 1'b0;
    always #5 ppu_clk = ~ppu_clk;

    always @(posedge ppu_clk) oam_rdata <= oam[oam_addr];

    always @(posedge ppu_clk) begin
        if (sec_we === 1'b1) begin
            wa.push_back(sec_addr);
            wd.push_back(sec_wdata);
            if (busy !== 1'b1) nstray++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_oam(input logic [7:0] y);
        for (int i = 0; i < 64; i++) begin
            oam[4*i]   = y;
            oam[4*i+1] = 8'($urandom);
            oam[4*i+2] = 8'($urandom);
            oam[4*i+3] = 8'($urandom);
        end
    endtask

    // Model: walk the sprite list in order, keep the first eight visible ones.
    task automatic run_eval(input string tag, input logic [7:0] ln, input logic tl,
                            input int pulse_at);
        int         exp_cnt, hits, misses, total, cyc, wr0, extra, h;
        bit         exp_ovf, exp_s0, stop;
        logic [7:0] exp_sec [32];
        logic [7:0] got [32];
        exp_cnt = 0; hits = 0; misses = 0; exp_ovf = 0; exp_s0 = 0; stop = 0;
        h = tl ? 16 : 8;
        for (int k = 0; k < 32; k++) exp_sec[k] = 8'hFF;
        for (int i = 0; i < 64 && !stop; i++) begin
            int y;
            y = int'(oam[4*i]);
            if (int'(ln) >= y && int'(ln) - y < h) begin
                if (exp_cnt == 8) begin
                    exp_ovf = 1; misses++; stop = 1;
                end else begin
                    for (int k = 0; k < 4; k++) exp_sec[4*exp_cnt+k] = oam[4*i+k];
                    if (i == 0) exp_s0 = 1;
                    exp_cnt++; hits++;
                end
            end else begin
                misses++;
            end
        end
        total = 1 + 32 + 2*misses + 5*hits + 1;

        wr0 = wa.size();
        @(negedge ppu_clk);
        line = ln; tall = tl; start = 1'b1;
        @(posedge ppu_clk); #1;
        start = 1'b0;
        cyc = 1;
        chk({tag, " busy after start"}, 32'(busy), 32'd1);
        while (done !== 1'b1 && cyc < 4000) begin
            if (pulse_at != 0) start = (cyc == pulse_at);
            @(posedge ppu_clk); #1;
            cyc++;
        end
        start = 1'b0;
        chk({tag, " done latency"}, 32'(cyc), 32'(total - 1));
        chk({tag, " busy at done"}, 32'(busy), 32'd0);
        chk({tag, " count"}, 32'(count), 32'(exp_cnt));
        chk({tag, " overflow"}, 32'(overflow), 32'(exp_ovf));
        chk({tag, " spr0_hit"}, 32'(spr0_hit), 32'(exp_s0));
        for (int k = 0; k < 32; k++) got[k] = 8'hAA;
        for (int j = wr0; j < wa.size(); j++) got[wa[j]] = wd[j];
        for (int k = 0; k < 32; k++)
            chk($sformatf("%s sec[%0d]", tag, k), 32'(got[k]), 32'(exp_sec[k]));
        chk({tag, " write count"}, 32'(wa.size() - wr0), 32'(32 + 4*exp_cnt));
        @(posedge ppu_clk); #1;
        chk({tag, " done one cycle"}, 32'(done), 32'd0);
        chk({tag, " count holds"}, 32'(count), 32'(exp_cnt));
        if (pulse_at != 0) begin
            extra = 0;
            repeat (40) begin
                @(posedge ppu_clk); #1;
                if (done === 1'b1) extra++;
            end
            chk({tag, " extra done"}, 32'(extra), 32'd0);
        end
    endtask

    initial begin
        int wr0;
        reset_n = 1'b0; start = 1'b0; line = '0; tall = 1'b0;
        fill_oam(8'hF0);
        repeat (3) @(posedge ppu_clk);
        #1;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset sec_we", 32'(sec_we), 32'd0);
        chk("reset addrs/data", {8'h0, oam_addr, 3'b0, sec_addr, sec_wdata}, 32'd0);
        chk("reset status", {count, overflow, spr0_hit}, 32'd0);
        @(negedge ppu_clk);
        reset_n = 1'b1;

        run_eval("clear-only", 8'd10, 1'b0, 0);

        fill_oam(8'hF0);
        oam[0] = 8'h05; oam[1] = 8'h21; oam[2] = 8'h03; oam[3] = 8'h40;
        run_eval("single", 8'd12, 1'b0, 0);

        fill_oam(8'hF0);
        oam[12] = 8'd20;
        run_eval("h8 line27", 8'd27, 1'b0, 0);
        run_eval("h8 line28", 8'd28, 1'b0, 0);
        run_eval("h8 line19", 8'd19, 1'b0, 0);
        run_eval("h16 line35", 8'd35, 1'b1, 0);
        run_eval("h16 line36", 8'd36, 1'b1, 0);

        fill_oam(8'hF0);
        for (int i = 0; i < 9; i++) oam[4*i] = 8'd100;
        run_eval("overflow", 8'd100, 1'b0, 0);

        fill_oam(8'hF0);
        oam[4*5] = 8'd50; oam[4*63] = 8'd45;
        run_eval("start while busy", 8'd52, 1'b0, 50);

        fill_oam(8'hFF);
        run_eval("Y=FF line255", 8'd255, 1'b1, 0);

        for (int r = 0; r < 8; r++) begin
            logic [7:0] ln;
            logic       tl;
            ln = 8'($urandom_range(0, 255));
            tl = 1'($urandom);
            for (int i = 0; i < 64; i++) begin
                if ($urandom_range(0, 3) == 0)
                    oam[4*i] = (ln > 8'd17) ? ln - 8'($urandom_range(0, 17)) : 8'($urandom_range(0, 20));
                else
                    oam[4*i] = 8'($urandom);
                oam[4*i+1] = 8'($urandom);
                oam[4*i+2] = 8'($urandom);
                oam[4*i+3] = 8'($urandom);
            end
            run_eval($sformatf("random%0d", r), ln, tl, 0);
        end

        fill_oam(8'hF0);
        oam[0] = 8'h05;
        @(negedge ppu_clk);
        line = 8'd12; tall = 1'b0; start = 1'b1;
        @(posedge ppu_clk); #1;
        start = 1'b0;
        repeat (35) @(posedge ppu_clk);
        #1;
        chk("pre-reset C2 sec_we", 32'(sec_we), 32'd1);
        chk("pre-reset C2 sec_addr", 32'(sec_addr), 32'd2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async reset busy", 32'(busy), 32'd0);
        chk("async reset sec_we", 32'(sec_we), 32'd0);
        chk("async reset addrs/data", {8'h0, oam_addr, 3'b0, sec_addr, sec_wdata}, 32'd0);
        chk("async reset status", {done, count, overflow, spr0_hit}, 32'd0);
        wr0 = wa.size();
        repeat (3) @(posedge ppu_clk);
        #1;
        chk("writes during reset", 32'(wa.size() - wr0), 32'd0);
        @(negedge ppu_clk);
        reset_n = 1'b1;
        oam[4*7] = 8'd10;
        run_eval("after reset", 8'd12, 1'b0, 0);

        chk("stray writes", 32'(nstray), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

`default_nettype wire
